// File: rtl/noc_pkg.sv
// noc_pkg: shared definitions for the NoC run sequencer.
//   OP_W       width of every router/traffic op code
//   OP_*       op codes broadcast to routers and traffic sources
//   noc_state_e sequencer FSM state encoding
package noc_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_NOP          = 4'd0;
  localparam logic [OP_W-1:0] OP_PHASE0       = 4'd1;
  localparam logic [OP_W-1:0] OP_PHASE1       = 4'd2;
  localparam logic [OP_W-1:0] OP_LOAD_STAGING = 4'd3;
  localparam logic [OP_W-1:0] OP_LOAD_RT      = 4'd4;
  localparam logic [OP_W-1:0] OP_INIT         = 4'd5;
  localparam logic [OP_W-1:0] OP_FILL         = 4'd6;
  localparam logic [OP_W-1:0] OP_DEQUEUE      = 4'd7;
  localparam logic [OP_W-1:0] OP_PREDEQUE     = 4'd8;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INIT_TRAFFIC,
    ST_FILL_TRAFFIC,
    ST_PRE_DEQUE,
    ST_INIT_ROUTER,
    ST_LOAD_RT,
    ST_LOAD_STAGING,
    ST_PHASE0,
    ST_PHASE1,
    ST_CHECK_END,
    ST_DONE
  } noc_state_e;

endpackage

// File: rtl/noc_fill_cnt.sv
// noc_fill_cnt: remaining-packet counter for one traffic source.
// Ports:
//   clk, rst_n    clock, async active-low reset
//   load, load_val  load a new packet count (takes priority over dec)
//   dec           decrement by one; ignored when already zero
//   nonzero       count is above zero
//   more          count stays above zero after a decrement this cycle
module noc_fill_cnt #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         nonzero,
  output logic         more
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && nonzero) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign nonzero = (cnt_q != '0);
  assign more    = (cnt_q > W'(1));

endmodule

// File: rtl/noc_seq_ctrl.sv
// noc_seq_ctrl: sequences a NoC simulation run across ROUTERS router/traffic
// pairs: traffic init and fill, router init, routing-table load, then the
// staging/phase0/phase1/check loop until all routers drain.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   start          run request, accepted only in IDLE
//   traffic_cnt    packets per router (router i at [i*TRAFFIC_W +: TRAFFIC_W])
//   max_cycle      timeout limit in simulated cycles (0 = no limit)
//   router_done    per-router drained flag
//   inject_ok      per-router injection permitted
//   router_op      op broadcast to all routers
//   traffic_op     per-traffic-source op (source i at [i*OP_W +: OP_W])
//   rt_index       routing-table destination being loaded
//   fill_index     packet slot being filled
//   in_cycle       completed simulated cycles (saturating)
//   busy, finished, timeout  run status
// Build option: define NOC_SEQ_TIMEOUT_EN to enable the max_cycle timeout.
//
// state        | meaning
// IDLE         | waiting for start
// INIT_TRAFFIC | all traffic sources INIT
// FILL_TRAFFIC | FILL sources with packets remaining
// PRE_DEQUE    | all traffic sources PREDEQUE
// INIT_ROUTER  | all routers INIT
// LOAD_RT      | load routing table, one destination per cycle
// LOAD_STAGING | routers stage, permitted sources dequeue
// PHASE0       | router pipeline phase 0
// PHASE1       | router pipeline phase 1, cycle count advances
// CHECK_END    | finish if all drained (or timed out)
// DONE         | one-cycle run end, status held
module noc_seq_ctrl
  import noc_pkg::*;
#(
  parameter int ROUTERS   = 16,
  parameter int TRAFFIC_W = 10,
  parameter int CYCLE_W   = 32,
  localparam int RT_W     = (ROUTERS > 1) ? $clog2(ROUTERS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [ROUTERS*TRAFFIC_W-1:0] traffic_cnt,
  input  logic [CYCLE_W-1:0]        max_cycle,
  input  logic [ROUTERS-1:0]        router_done,
  input  logic [ROUTERS-1:0]        inject_ok,
  output logic [OP_W-1:0]           router_op,
  output logic [ROUTERS*OP_W-1:0]   traffic_op,
  output logic [RT_W-1:0]           rt_index,
  output logic [TRAFFIC_W-1:0]      fill_index,
  output logic [CYCLE_W-1:0]        in_cycle,
  output logic                      busy,
  output logic                      finished,
  output logic                      timeout
);

  localparam logic [RT_W-1:0] RT_LAST = RT_W'(ROUTERS - 1);

  noc_state_e state_q, state_d;

  logic               start_ok, fill_inc, rt_inc, cyc_inc, set_fin, set_to;
  logic [ROUTERS-1:0] cnt_dec, cnt_nz, cnt_more;
  logic               timeout_hit;

  for (genvar g = 0; g < ROUTERS; g++) begin : g_cnt
    noc_fill_cnt #(.W(TRAFFIC_W)) u_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (start_ok),
      .load_val (traffic_cnt[g*TRAFFIC_W +: TRAFFIC_W]),
      .dec      (cnt_dec[g]),
      .nonzero  (cnt_nz[g]),
      .more     (cnt_more[g])
    );
  end

`ifdef NOC_SEQ_TIMEOUT_EN
  logic [CYCLE_W-1:0] max_cycle_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) max_cycle_q <= '0;
    else if (start_ok) max_cycle_q <= max_cycle;
  end

  assign timeout_hit = (max_cycle_q != '0) && (in_cycle >= max_cycle_q);
`else
  logic max_cycle_unused;
  assign max_cycle_unused = ^max_cycle;
  assign timeout_hit      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    router_op  = OP_NOP;
    traffic_op = '0;
    cnt_dec    = '0;
    start_ok   = 1'b0;
    fill_inc   = 1'b0;
    rt_inc     = 1'b0;
    cyc_inc    = 1'b0;
    set_fin    = 1'b0;
    set_to     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          start_ok = 1'b1;
          state_d  = ST_INIT_TRAFFIC;
        end
      end
      ST_INIT_TRAFFIC: begin
        for (int i = 0; i < ROUTERS; i++) traffic_op[i*OP_W +: OP_W] = OP_INIT;
        state_d = ST_FILL_TRAFFIC;
      end
      ST_FILL_TRAFFIC: begin
        for (int i = 0; i < ROUTERS; i++) begin
          if (cnt_nz[i]) begin
            traffic_op[i*OP_W +: OP_W] = OP_FILL;
            cnt_dec[i]                 = 1'b1;
          end
        end
        fill_inc = 1'b1;
        // cnt_more looks past this cycle's decrement
        state_d  = (|cnt_more) ? ST_FILL_TRAFFIC : ST_PRE_DEQUE;
      end
      ST_PRE_DEQUE: begin
        for (int i = 0; i < ROUTERS; i++) traffic_op[i*OP_W +: OP_W] = OP_PREDEQUE;
        state_d = ST_INIT_ROUTER;
      end
      ST_INIT_ROUTER: begin
        router_op = OP_INIT;
        state_d   = ST_LOAD_RT;
      end
      ST_LOAD_RT: begin
        router_op = OP_LOAD_RT;
        // rt_index parks on the last destination rather than wrapping
        if (rt_index == RT_LAST) state_d = ST_LOAD_STAGING;
        else                     rt_inc  = 1'b1;
      end
      ST_LOAD_STAGING: begin
        router_op = OP_LOAD_STAGING;
        for (int i = 0; i < ROUTERS; i++) begin
          if (inject_ok[i]) traffic_op[i*OP_W +: OP_W] = OP_DEQUEUE;
        end
        state_d = ST_PHASE0;
      end
      ST_PHASE0: begin
        router_op = OP_PHASE0;
        state_d   = ST_PHASE1;
      end
      ST_PHASE1: begin
        router_op = OP_PHASE1;
        cyc_inc   = 1'b1;
        state_d   = ST_CHECK_END;
      end
      ST_CHECK_END: begin
        if (&router_done) begin
          set_fin = 1'b1;
          state_d = ST_DONE;
        end else if (timeout_hit) begin
          set_to  = 1'b1;
          state_d = ST_DONE;
        end else begin
          state_d = ST_LOAD_STAGING;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rt_index   <= '0;
      fill_index <= '0;
      in_cycle   <= '0;
      finished   <= 1'b0;
      timeout    <= 1'b0;
    end else if (start_ok) begin
      rt_index   <= '0;
      fill_index <= '0;
      in_cycle   <= '0;
      finished   <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      if (rt_inc)   rt_index   <= rt_index + RT_W'(1);
      if (fill_inc) fill_index <= fill_index + TRAFFIC_W'(1);
      if (cyc_inc && (in_cycle != '1)) in_cycle <= in_cycle + CYCLE_W'(1);
      if (set_fin)  finished   <= 1'b1;
      if (set_to)   timeout    <= 1'b1;
    end
  end

  assign busy = (state_q != ST_IDLE) && (state_q != ST_DONE);

endmodule

// File: tb/tb_noc_seq_ctrl.sv
// Directed bench for noc_seq_ctrl with ROUTERS=4. Expected values are
// hand-derived from the sequencer's state order.
module tb_noc_seq_ctrl;
  import noc_pkg::*;

  localparam int R  = 4;
  localparam int TW = 10;
  localparam int CW = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [R*TW-1:0]   traffic_cnt;
  logic [CW-1:0]     max_cycle;
  logic [R-1:0]      router_done;
  logic [R-1:0]      inject_ok;
  logic [OP_W-1:0]   router_op;
  logic [R*OP_W-1:0] traffic_op;
  logic [1:0]        rt_index;
  logic [TW-1:0]     fill_index;
  logic [CW-1:0]     in_cycle;
  logic              busy, finished, timeout;

  int n_checks = 0;
  int n_fail   = 0;

  noc_seq_ctrl #(.ROUTERS(R), .TRAFFIC_W(TW), .CYCLE_W(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .traffic_cnt (traffic_cnt),
    .max_cycle   (max_cycle),
    .router_done (router_done),
    .inject_ok   (inject_ok),
    .router_op   (router_op),
    .traffic_op  (traffic_op),
    .rt_index    (rt_index),
    .fill_index  (fill_index),
    .in_cycle    (in_cycle),
    .busy        (busy),
    .finished    (finished),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    traffic_cnt = '0;
    max_cycle   = '0;
    router_done = 4'hF;
    inject_ok   = 4'b0101;
    #12;
    check("rst_router_op", router_op, 0);
    check("rst_traffic_op", traffic_op, 0);
    check("rst_in_cycle", in_cycle, 0);
    check("rst_status", {busy, finished, timeout}, 0);
    rst_n = 1'b1;
    tick();

    // Run 1: all counts zero, all routers done
    pulse_start();
    check("r1_init_traffic", traffic_op, 16'h5555);
    check("r1_busy", busy, 1);
    tick();
    check("r1_fill_nop", traffic_op, 16'h0000);
    tick();
    check("r1_predeque", traffic_op, 16'h8888);
    check("r1_fill_index", fill_index, 1);
    tick();
    check("r1_init_router", router_op, OP_INIT);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("r1_load_rt_op", router_op, OP_LOAD_RT);
      check("r1_rt_index", rt_index, k);
    end
    tick();
    check("r1_staging_op", router_op, OP_LOAD_STAGING);
    check("r1_staging_traffic", traffic_op, 16'h0707);
    tick();
    check("r1_phase0", {router_op, traffic_op}, {OP_PHASE0, 16'h0000});
    tick();
    check("r1_phase1", router_op, OP_PHASE1);
    check("r1_in_cycle_p1", in_cycle, 0);
    tick();
    check("r1_check_end", {router_op, busy}, {OP_NOP, 1'b1});
    check("r1_in_cycle_ce", in_cycle, 1);
    tick();
    check("r1_done", {busy, finished, timeout}, 3'b010);
    check("r1_done_in_cycle", in_cycle, 1);
    tick();
    check("r1_idle_hold", {busy, finished, timeout}, 3'b010);

    // Run 2: counts {3,0,1,0}; start during LOAD_RT; reset during PHASE0
    traffic_cnt = {10'd0, 10'd1, 10'd0, 10'd3};
    inject_ok   = 4'b1010;
    router_done = 4'b0111;
    pulse_start();
    check("r2_finished_cleared", finished, 0);
    tick();
    check("r2_fill1", traffic_op, 16'h0606);
    tick();
    check("r2_fill2", traffic_op, 16'h0006);
    tick();
    check("r2_fill3", traffic_op, 16'h0006);
    tick();
    check("r2_predeque", traffic_op, 16'h8888);
    check("r2_fill_index", fill_index, 3);
    tick();
    tick();
    check("r2_rt0", {router_op, rt_index}, {OP_LOAD_RT, 2'd0});
    start = 1'b1;
    tick();
    start = 1'b0;
    check("r2_rt1", {router_op, rt_index}, {OP_LOAD_RT, 2'd1});
    tick();
    check("r2_rt2", {router_op, rt_index}, {OP_LOAD_RT, 2'd2});
    tick();
    check("r2_rt3", {router_op, rt_index}, {OP_LOAD_RT, 2'd3});
    tick();
    check("r2_staging", {router_op, traffic_op}, {OP_LOAD_STAGING, 16'h7070});
    tick();
    tick();
    tick();
    check("r2_ce_not_done", {router_op, in_cycle[7:0], busy}, {OP_NOP, 8'd1, 1'b1});
    tick();
    check("r2_back_to_staging", router_op, OP_LOAD_STAGING);
    tick();
    check("r2_phase0", router_op, OP_PHASE0);
    rst_n = 1'b0;
    #1;
    check("r2_rst_ops", {router_op, traffic_op}, 0);
    check("r2_rst_counts", {in_cycle, fill_index, rt_index}, 0);
    check("r2_rst_status", {busy, finished, timeout}, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("r2_idle_after_rst", busy, 0);

    // Run 3: normal run after the mid-run reset
    traffic_cnt = '0;
    router_done = 4'hF;
    pulse_start();
    for (int k = 0; k < 13; k++) tick();
    check("r3_done", {busy, finished, timeout, in_cycle[7:0]}, {3'b010, 8'd1});

    // Run 4: no router drains, max_cycle = 5
    tick();
    router_done = 4'h0;
    max_cycle   = 32'd5;
    pulse_start();
    begin
      int budget = 0;
      while (busy && budget < 200) begin
        tick();
        budget++;
      end
`ifdef NOC_SEQ_TIMEOUT_EN
      check("r4_terminated", busy, 0);
      check("r4_timeout", {finished, timeout}, 2'b01);
      check("r4_in_cycle", in_cycle, 5);
`else
      check("r4_still_busy", busy, 1);
      check("r4_no_timeout", {finished, timeout}, 2'b00);
`endif
    end

    rst_n = 1'b0;
    #1;
    check("end_rst_idle", {busy, router_op}, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
